// File: rtl/opsel_issue_ctrl.sv
// Issue-stage controller: per-register writeback scoreboard, hazard stall, and
// registered RF read addresses plus OPSEL control codes for the operand select stage.
module opsel_issue_ctrl #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned SCNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [AW-1:0]     src_a_i,
    input  logic [AW-1:0]     src_b_i,
    input  logic              use_a_i,
    input  logic              use_b_i,
    input  logic              use_imm_i,
    input  logic              swap_i,
    input  logic [AW-1:0]     dst_i,
    input  logic              dst_we_i,
    input  logic [1:0]        dst_lat_i,
    input  logic              flush_i,
    output logic [AW-1:0]     rf_addr_a_o,
    output logic [AW-1:0]     rf_addr_b_o,
    output logic [CTRL_W-1:0] opsel_ctrl_o,
    output logic              opsel_valid_o,
    output logic [SCNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] OPA_PORT_A = 2'd0;
    localparam logic [1:0] OPA_PORT_B = 2'd1;
    localparam logic [1:0] OPB_PORT_B = 2'd0;
    localparam logic [1:0] OPB_PORT_A = 2'd1;
    localparam logic [1:0] OPB_IMM    = 2'd2;

    logic [NREG-1:0][1:0] pend_q, pend_d;
    logic [AW-1:0]        addr_a_q, addr_b_q;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic                 valid_q;
    logic [SCNT_W-1:0]    stall_q;

    logic                 hazard_c;
    logic                 ready_c;
    logic                 accept_c;
    logic                 stall_c;
    logic [1:0]           lat_eff_c;
    logic [1:0]           opa_c, opb_c;

    // Hazard check against the current (pre-decrement) scoreboard values.
    always_comb begin
        hazard_c = 1'b0;
        if (use_a_i && (pend_q[src_a_i] != 2'd0)) hazard_c = 1'b1;
        if (use_b_i && !use_imm_i && (pend_q[src_b_i] != 2'd0)) hazard_c = 1'b1;
        if (dst_we_i && (pend_q[dst_i] != 2'd0)) hazard_c = 1'b1;
    end

    assign ready_c       = !hazard_c && !flush_i;
    assign accept_c      = issue_valid_i && ready_c;
    assign stall_c       = issue_valid_i && !ready_c && !flush_i;
    assign issue_ready_o = ready_c;

    // A zero latency is illegal; treat it as a single-cycle writeback.
    assign lat_eff_c = (dst_lat_i == 2'd0) ? 2'd1 : dst_lat_i;

    // Scoreboard next state: drain every counter, a new write load wins.
    always_comb begin
        pend_d = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (pend_q[r] != 2'd0) pend_d[r] = pend_q[r] - 2'd1;
        end
        if (accept_c && dst_we_i) pend_d[dst_i] = lat_eff_c;
    end

    always_comb begin
        opa_c  = swap_i ? OPA_PORT_B : OPA_PORT_A;
        opb_c  = use_imm_i ? OPB_IMM : (swap_i ? OPB_PORT_A : OPB_PORT_B);
        ctrl_d = accept_c ? CTRL_W'({opb_c, opa_c}) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            ctrl_q  <= ctrl_d;
            valid_q <= accept_c;
            if (accept_c) begin
                addr_a_q <= src_a_i;
                addr_b_q <= src_b_i;
            end
            if (stall_c && (stall_q != '1)) stall_q <= stall_q + SCNT_W'(1);
        end
    end

    assign rf_addr_a_o   = addr_a_q;
    assign rf_addr_b_o   = addr_b_q;
    assign opsel_ctrl_o  = ctrl_q;
    assign opsel_valid_o = valid_q;
    assign stall_cnt_o   = stall_q;

    // Simulation-only guard: a writer must not present a zero latency.
    a_lat_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(issue_valid_i && dst_we_i && (dst_lat_i == 2'd0)))
        else $fatal(1, "opsel_issue_ctrl: dst_lat_i=0 with dst_we_i=1");

endmodule

// File: tb/tb_opsel_issue_ctrl.sv
// Self-checking bench for opsel_issue_ctrl: directed scenarios plus random
// traffic, compared every cycle against a busy-until-cycle reference model.
module tb_opsel_issue_ctrl;

    localparam int NREG = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] src_a, src_b, dst;
    logic       use_a, use_b, use_imm, swap, dst_we, flush;
    logic [1:0] dst_lat;
    logic [4:0] rf_addr_a, rf_addr_b;
    logic [3:0] opsel_ctrl;
    logic       opsel_valid;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: register r is blocked while cyc <= busy_until[r].
    int cyc;
    int busy_until [NREG];
    int e_valid, e_a, e_b, e_ctrl, e_stall;
    bit last_acc;

    always #5 clk = ~clk;

    opsel_issue_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .src_a_i       (src_a),
        .src_b_i       (src_b),
        .use_a_i       (use_a),
        .use_b_i       (use_b),
        .use_imm_i     (use_imm),
        .swap_i        (swap),
        .dst_i         (dst),
        .dst_we_i      (dst_we),
        .dst_lat_i     (dst_lat),
        .flush_i       (flush),
        .rf_addr_a_o   (rf_addr_a),
        .rf_addr_b_o   (rf_addr_b),
        .opsel_ctrl_o  (opsel_ctrl),
        .opsel_valid_o (opsel_valid),
        .stall_cnt_o   (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NREG; i++) busy_until[i] = -1;
        e_valid = 0; e_a = 0; e_b = 0; e_ctrl = 0; e_stall = 0;
    endtask

    task automatic drive(input bit v, input int sa, input int sb, input bit ua, input bit ub,
                         input bit imm, input bit sw, input int d, input bit we, input int lat,
                         input bit fl);
        issue_valid = v; src_a = 5'(sa); src_b = 5'(sb); use_a = ua; use_b = ub;
        use_imm = imm; swap = sw; dst = 5'(d); dst_we = we; dst_lat = 2'(lat); flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // One clock: check ready against the model, advance model, check registered outputs.
    task automatic step();
        bit hz, rdy, acc;
        int opa, opb;
        #1;
        hz = (use_a && cyc <= busy_until[src_a]) ||
             (use_b && !use_imm && cyc <= busy_until[src_b]) ||
             (dst_we && cyc <= busy_until[dst]);
        rdy = !hz && !flush;
        chk("issue_ready", 32'(issue_ready), 32'(rdy));
        acc = issue_valid && rdy;
        if (acc) begin
            opa = swap ? 1 : 0;
            opb = use_imm ? 2 : (swap ? 1 : 0);
            e_valid = 1; e_a = int'(src_a); e_b = int'(src_b); e_ctrl = opb * 4 + opa;
            if (dst_we) busy_until[dst] = cyc + int'(dst_lat);
        end else begin
            e_valid = 0; e_ctrl = 0;
        end
        if (issue_valid && !rdy && !flush && e_stall < 65535) e_stall++;
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
        chk("opsel_valid", 32'(opsel_valid), 32'(e_valid));
        chk("opsel_ctrl", 32'(opsel_ctrl), 32'(e_ctrl));
        chk("rf_addr_a", 32'(rf_addr_a), 32'(e_a));
        chk("rf_addr_b", 32'(rf_addr_b), 32'(e_b));
        chk("stall_cnt", 32'(stall_cnt), 32'(e_stall));
        @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        last_acc = 0;
        reset_model();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(opsel_valid), 32'd0);
        chk("rst_ctrl", 32'(opsel_ctrl), 32'd0);
        chk("rst_addr_a", 32'(rf_addr_a), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;

        // Plain issue, then the two swap/immediate encodings.
        drive(1, 3, 4, 1, 1, 0, 0, 0, 0, 1, 0); step();
        chk("plain_valid", 32'(opsel_valid), 32'd1);
        chk("plain_a", 32'(rf_addr_a), 32'd3);
        chk("plain_b", 32'(rf_addr_b), 32'd4);
        chk("plain_ctrl", 32'(opsel_ctrl), 32'b0000);
        drive(1, 1, 2, 1, 1, 1, 1, 0, 0, 1, 0); step();
        chk("imm_swap_ctrl", 32'(opsel_ctrl), 32'b1001);
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0, 1, 0); step();
        chk("swap_ctrl", 32'(opsel_ctrl), 32'b0101);

        // RAW: writer r5 latency 3, reader blocked exactly 3 cycles.
        drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 3, 0); step();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("raw_ready", 32'(issue_ready), (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("raw_stall", 32'(stall_cnt), 32'd3);
        chk("raw_addr", 32'(rf_addr_a), 32'd5);

        // WAW: back-to-back writers of r7, then an immediate operand ignores r7.
        drive(1, 0, 0, 0, 0, 0, 0, 7, 1, 2, 0); step();
        for (int i = 0; i < 3; i++) begin
            #1 chk("waw_ready", 32'(issue_ready), (i == 2) ? 32'd1 : 32'd0);
            step();
        end
        chk("waw_stall", 32'(stall_cnt), 32'd5);
        drive(1, 0, 7, 0, 1, 1, 0, 0, 0, 1, 0);
        #1 chk("imm_no_hazard", 32'(issue_ready), 32'd1);
        step();
        chk("imm_ctrl", 32'(opsel_ctrl), 32'b1000);

        // Flush blocks issue without counting; the r5 write still drains.
        idle(); repeat (3) step();
        drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 3, 0); step();
        drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        #1 chk("flush_ready", 32'(issue_ready), 32'd0);
        step();
        chk("flush_valid", 32'(opsel_valid), 32'd0);
        chk("flush_stall", 32'(stall_cnt), 32'd5);
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("drain_ready", 32'(issue_ready), (i == 2) ? 32'd1 : 32'd0);
            step();
        end
        chk("drain_stall", 32'(stall_cnt), 32'd7);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(7, 0), 1'($urandom), $urandom_range(3, 1),
                  $urandom_range(7, 0) == 0);
            step();
        end

        // Saturation: a writer of r5 held valid stalls 3 of every 4 cycles.
        drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 3, 0);
        for (int i = 0; i < 87400; i++) step();
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);

        // Reset while a reader of r5 is stalled.
        for (int i = 0; i < 8 && !last_acc; i++) step();
        chk("writer_seen", 32'(last_acc), 32'd1);
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0); step();
        chk("pre_rst_stalled", 32'(opsel_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(opsel_valid), 32'd0);
        chk("mid_rst_ctrl", 32'(opsel_ctrl), 32'd0);
        chk("mid_rst_addr_a", 32'(rf_addr_a), 32'd0);
        chk("mid_rst_addr_b", 32'(rf_addr_b), 32'd0);
        chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(issue_ready), 32'd1);
        step();
        chk("post_rst_valid", 32'(opsel_valid), 32'd1);
        chk("post_rst_addr", 32'(rf_addr_a), 32'd5);
        chk("post_rst_stall", 32'(stall_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opsel_issue_ctrl.md
Name: opsel_issue_ctrl

Overview:
- Issue-stage controller in front of the operand select stage.
- Keeps a per-register writeback scoreboard and stalls instructions whose source or destination registers have writes in flight.
- For each accepted instruction, issues registered register-file read addresses and OPSEL control codes (OPA/OPB fields).
- Counts stall cycles for performance monitoring.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).
- CTRL_W, 4, OPSEL control width; OPA field is bits [1:0], OPB field is bits [3:2].
- SCNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous reset, active low.
- issue_valid_i  in  1  decoder presents an instruction.
- issue_ready_o  out  1  controller can accept it this cycle (combinational).
- src_a_i  in  AW  source register A.
- src_b_i  in  AW  source register B.
- use_a_i  in  1  instruction reads src_a_i.
- use_b_i  in  1  instruction reads src_b_i.
- use_imm_i  in  1  operand B is the immediate.
- swap_i  in  1  operand A is taken from RF port B.
- dst_i  in  AW  destination register.
- dst_we_i  in  1  instruction writes dst_i.
- dst_lat_i  in  2  writeback latency in cycles, 1..3; 0 is illegal.
- flush_i  in  1  pipeline flush.
- rf_addr_a_o  out  AW  registered RF read address A.
- rf_addr_b_o  out  AW  registered RF read address B.
- opsel_ctrl_o  out  CTRL_W  registered OPSEL control.
- opsel_valid_o  out  1  registered: outputs hold an accepted instruction.
- stall_cnt_o  out  SCNT_W  saturating stall-cycle counter.

Behaviour:
- Reset (async, rst_n_i=0): all scoreboard counters = 0; rf_addr_a_o = 0, rf_addr_b_o = 0, opsel_ctrl_o = 0, opsel_valid_o = 0, stall_cnt_o = 0.
- Scoreboard:
  - One 2-bit pending counter per register.
  - Each cycle, every nonzero counter decrements by 1.
  - On accept with dst_we_i=1, pend[dst_i] loads dst_lat_i. The load takes priority over the decrement for that register.
- Hazard (combinational, evaluated on current counter values):
  - (use_a_i & pend[src_a_i]!=0), or
  - (use_b_i & !use_imm_i & pend[src_b_i]!=0), or
  - (dst_we_i & pend[dst_i]!=0), the WAW case.
- issue_ready_o = !hazard & !flush_i.
- Accept = issue_valid_i & issue_ready_o.
- Outputs on the clock edge after accept:
  - opsel_valid_o = 1.
  - rf_addr_a_o = src_a_i, rf_addr_b_o = src_b_i.
  - OPA field = 1 if swap_i, else 0.
  - OPB field = 2 if use_imm_i, else 1 if swap_i, else 0.
  - Code 3 is never emitted in either field.
- No accept (stall, idle or flush): opsel_valid_o = 0 and opsel_ctrl_o = 0. The address outputs hold their last value.
- Latency: accept to outputs is 1 cycle. A register written with latency L blocks readers for exactly L cycles after the accept cycle, so the first legal reader is accepted L+1 cycles after the writer.
- Flush:
  - flush_i=1 blocks acceptance that cycle.
  - opsel_valid_o = 0 next cycle.
  - Scoreboard counters are not cleared; already-issued writes complete.
- Stall counter:
  - Increments when issue_valid_i & !issue_ready_o & !flush_i.
  - Saturates at all-ones; no wrap.
- Illegal input: dst_lat_i=0 with dst_we_i=1 is treated as latency 1; the simulation-only check stops the simulation.
- Reset mid-operation: all in-flight scoreboard state is discarded and the block comes up with no hazards.

Test Plan:
- Reset, then issue src_a=3, src_b=4, no imm/swap → next cycle: opsel_valid_o=1, rf_addr_a_o=3, rf_addr_b_o=4, opsel_ctrl_o=4'b0000.
- Issue with use_imm_i=1 and swap_i=1 → opsel_ctrl_o=4'b1001. Issue with swap_i only → 4'b0101.
- Writer dst=5, lat=3 at cycle 0, then reader of r5 held valid → issue_ready_o=0 in cycles 1–3, accept in cycle 4, stall_cnt_o=3.
- WAW: writer dst=7 lat=2, then second writer dst=7 → 2 stall cycles. A reader of r7 via use_imm_i on port B (use_b_i=1) is not stalled.
- Flush while valid, no hazard → no accept, opsel_valid_o=0 next cycle, stall_cnt_o unchanged, pending r5 counter still drains.
- Force 65540 stall cycles → stall_cnt_o = 16'hFFFF. Then assert rst_n_i=0 mid-stall → all outputs 0 immediately, and the reader is accepted on the first cycle after release.
